// File: rtl/pe_rx_checker.sv
// pe_rx_checker: mesh NoC sink checking destination and per-source sequence order; counts packets and errors.
// Latency: a flit handshaken at edge E is checked at edge E+1, when counters, flags and done update.
// Backpressure: o_ready is registered; pseudo-random stalls only when PE_RX_BACKPRESSURE_EN is defined.
module pe_rx_checker #(
    parameter int xcord          = 0,
    parameter int ycord          = 0,
    parameter int X              = 2,
    parameter int Y              = 2,
    parameter int x_size         = 1,
    parameter int y_size         = 1,
    parameter int data_width     = 256,
    parameter int total_width    = x_size + y_size + data_width,
    parameter int expected_pckts = 100,
    parameter int stall_rate     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [total_width-1:0] i_data,
    output logic                   o_ready,
    output logic [15:0]            rcv_count,
    output logic [15:0]            err_count,
    output logic [2:0]             err_flags,
    output logic                   done
);
    localparam int NODES  = X * Y;
    localparam int SRC_W  = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int SEQ_LO = x_size + y_size;
    localparam logic [x_size-1:0] XC = x_size'(xcord);
    localparam logic [y_size-1:0] YC = y_size'(ycord);

    typedef struct packed {
        logic [data_width-1:0] payload;
        logic [y_size-1:0]     dest_y;
        logic [x_size-1:0]     dest_x;
    } flit_t;

    typedef enum logic {st_run, st_done} state_t;

    state_t            state, state_nxt;
    flit_t             cap_q;
    logic              chk_vld;
    logic [15:0]       exp_seq [NODES];

    logic [x_size-1:0] src_x;
    logic [y_size-1:0] src_y;
    logic [15:0]       seq;
    logic [31:0]       src_full;
    logic [SRC_W-1:0]  src_idx;
    logic              src_ok;
    logic              hs;
    logic              dest_err, seq_err, extra_err, any_err;
    logic [15:0]       rcv_inc, err_inc;

    assign hs       = i_valid && o_ready;
    assign src_x    = cap_q.payload[x_size-1:0];
    assign src_y    = cap_q.payload[SEQ_LO-1:x_size];
    assign seq      = cap_q.payload[SEQ_LO+15:SEQ_LO];
    assign src_full = 32'(src_x) + 32'(X) * 32'(src_y);
    assign src_ok   = src_full < 32'(NODES);
    assign src_idx  = src_full[SRC_W-1:0];
    assign done     = (state == st_done);

    // Filler payload bits and the upper source-index bits carry no checked information.
    logic unused_bits;
    assign unused_bits = ^{cap_q.payload, src_full};

    always_comb begin
        dest_err  = (cap_q.dest_x != XC) || (cap_q.dest_y != YC);
        seq_err   = !src_ok || (seq != exp_seq[src_idx]);
        extra_err = (state == st_done);
        any_err   = dest_err || seq_err || extra_err;
        rcv_inc   = (rcv_count == 16'hFFFF) ? rcv_count : rcv_count + 16'd1;
        err_inc   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_run;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            st_run: begin
                if (expected_pckts == 0 ||
                    (chk_vld && 32'(rcv_inc) == 32'(expected_pckts))) begin
                    state_nxt = st_done;
                end
            end
            default: state_nxt = st_done;
        endcase
    end

    // Capture and check run in parallel, so a new flit never waits on the check.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_vld   <= 1'b0;
            cap_q     <= '0;
            rcv_count <= 16'd0;
            err_count <= 16'd0;
            err_flags <= 3'b000;
            for (int i = 0; i < NODES; i++) begin
                exp_seq[i] <= 16'd0;
            end
        end else begin
            chk_vld <= hs;
            if (hs) begin
                cap_q <= i_data;
            end
            if (chk_vld) begin
                rcv_count <= rcv_inc;
                if (any_err) begin
                    err_count <= err_inc;
                end
                err_flags <= err_flags | {extra_err, seq_err, dest_err};
                if (src_ok) begin
                    exp_seq[src_idx] <= seq + 16'd1;
                end
            end
        end
    end

`ifdef PE_RX_BACKPRESSURE_EN
    localparam logic [15:0] SEED_RAW = 16'hACE1 ^ {8'(xcord), 8'(ycord)};
    localparam logic [15:0] SEED     = (SEED_RAW == 16'd0) ? 16'hACE1 : SEED_RAW;
    localparam logic [6:0]  STALL    = 7'(stall_rate);

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    always_comb begin
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (lfsr_nxt == 16'd0) begin
            lfsr_nxt = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= SEED;
            o_ready <= 1'b0;
        end else begin
            lfsr    <= lfsr_nxt;
            o_ready <= (lfsr[6:0] >= STALL);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (stall_rate != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ready <= 1'b0;
        end else begin
            o_ready <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/pe_rx_checker.md
# pe_rx_checker

Per-node traffic sink and checker for the mesh NoC test bench. It is the receive-side counterpart of the random packet generator PE. It accepts packets ejected by the router at node (xcord, ycord) and applies optional pseudo-random backpressure. It checks every packet's destination and per-source sequence order, counts packets and errors, and raises `done` once the expected packet count has arrived.

## Interface
- `xcord`, 0, X coordinate of this node.
- `ycord`, 0, Y coordinate of this node.
- `X`, 2, mesh width.
- `Y`, 2, mesh height.
- `x_size`, 1, destination-X field width.
- `y_size`, 1, destination-Y field width.
- `data_width`, 256, payload width; must be >= x_size+y_size+16.
- `total_width`, x_size+y_size+data_width, flit width.
- `expected_pckts`, 100, packets this node must receive before `done` asserts.
- `stall_rate`, 0, backpressure threshold in the range 0..127; 0 means never stall.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  flit valid from router.
- `i_data`  in  total_width  flit.
- `o_ready`  out  1  sink ready to router.
- `rcv_count`  out  16  accepted packets, saturating.
- `err_count`  out  16  packets with any error, saturating.
- `err_flags`  out  3  sticky flags {extra, seq, dest}.
- `done`  out  1  expected count reached.

## Operation
- Flit layout, LSB first:
  - dest_x = [x_size-1:0]
  - dest_y = [x_size+y_size-1:x_size]
  - payload = remainder
- Payload layout, LSB first: src_x (x_size bits), src_y (y_size bits), seq (16 bits), filler.
- Transfer occurs when `i_valid && o_ready` on a rising edge. `i_data` is captured into a single check register with a valid bit.
- Check stage, one cycle after capture:
  - dest error: dest_x != xcord or dest_y != ycord.
  - seq error: seq != exp_seq[src], where src = src_x + X*src_y. exp_seq is a table of X*Y 16-bit entries, reset to 0.
  - exp_seq[src] is always reloaded with seq+1 (wrapping 16'hFFFF -> 0). The checker therefore resyncs after a gap.
  - src outside the range 0..X*Y-1 counts as a seq error, and no table write occurs.
  - extra error: packet checked while in the DONE state.
  - rcv_count increments on every checked packet. err_count increments once per packet with at least one error. Both counters hold at 16'hFFFF.
  - err_flags bits set and stay set until reset.
- State machine:
  - RUN (entered from reset) -> DONE when a checked packet brings rcv_count to expected_pckts.
  - DONE is terminal until `rst`.
  - `expected_pckts` = 0 enters DONE on the first cycle after reset.
- In DONE the sink keeps accepting, so the network never deadlocks. Any packet accepted in DONE sets the extra flag.

## Timing
- Reset values: o_ready=0, rcv_count=0, err_count=0, err_flags=0, done=0, check-valid=0, exp_seq all 0, state RUN.
- With backpressure disabled, `o_ready` rises on the first cycle after `rst` deasserts.
- Latency: handshake at edge E captures the flit. Counters, flags and `done` update at edge E+1.
- Throughput is one packet per cycle. The check stage never stalls the capture stage.
- `o_ready` is registered and does not depend on `i_valid` in the same cycle. The router may keep `i_valid` high across stalls; no data is lost.
- `rst` asserted mid-packet discards the check register contents, and no count occurs for that packet.
- If a capture and a check coincide in one cycle, both proceed.

## Configuration
- `PE_RX_BACKPRESSURE_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with 16'hACE1 XOR {xcord,ycord}, and is not allowed to reach zero.
  - The LFSR advances every cycle after reset.
  - `o_ready` is registered as (lfsr[6:0] >= stall_rate). stall_rate=0 therefore gives always ready.
- Not defined: there is no LFSR, `o_ready` = 1 from the first cycle after reset, and `stall_rate` is ignored.

## Test plan
- X=Y=2, node (1,0), expected_pckts=4. Send four packets to (1,0) from src (0,0) with seq 0..3 on back-to-back cycles -> rcv_count=4, err_count=0, err_flags=0, `done` high one cycle after the 4th handshake.
- Send one packet addressed to (0,1) -> err_flags=3'b001, err_count=1, rcv_count=1.
- From src (1,1) send seq 0,1,3,4 -> err_flags[1]=1, err_count=1 (only seq 3 fails; 4 passes after resync).
- Reach `done`, then send one more valid packet -> accepted, err_flags[2]=1, rcv_count=expected_pckts+1.
- With `PE_RX_BACKPRESSURE_EN` and stall_rate=64, hold `i_valid` high with 1000 sequential packets -> `o_ready` low on roughly 50% of cycles, every packet counted once, err_count=0.
- Assert `rst` for one cycle on the edge after a capture -> all outputs return to reset values, and that packet is not counted.
